// File: rtl/jt6295_pkg.sv
// Shared constants for the jt6295 sample-ROM server: ROM address width, FSM encodings,
// and the memory-width to byte-select-width helper.
package jt6295_pkg;

   localparam int ROM_AW = 18;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_PREF = 2'd2;

   function automatic int bsel_w(input int mw);
      return $clog2(mw / 8);
   endfunction

endpackage

// File: rtl/jt6295_rom_line.sv
// One buffered memory word: tag/valid/data registers, hit comparator and byte mux.
// Invalidate has priority over a write in the same cycle.
module jt6295_rom_line
   import jt6295_pkg::*;
#(
   parameter int MW  = 32,
   parameter int MAW = 16,
   parameter int SW  = bsel_w(MW)
) (
   input  logic           rst,
   input  logic           clk,
   input  logic           clr,
   input  logic           wr,
   input  logic [MAW-1:0] wr_tag,
   input  logic [MW-1:0]  wr_data,
   input  logic [MAW-1:0] rd_tag,
   input  logic [SW-1:0]  rd_sel,
   output logic           hit,
   output logic [7:0]     rd_byte
);

   logic           valid;
   logic [MAW-1:0] tag;
   logic [MW-1:0]  data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (wr) begin
         valid <= 1'b1;
         tag   <= wr_tag;
         data  <= wr_data;
      end
   end

   assign hit     = valid && (tag == rd_tag);
   assign rd_byte = data[{rd_sel, 3'b000} +: 8];

endmodule

// File: rtl/jt6295_rom_server.sv
// Byte-wide ROM responder for jt6295 backed by a wider req/ack memory through a line buffer.
// JT6295_ROM_PREFETCH_EN: two lines plus a next-word prefetch after every demand fill.
module jt6295_rom_server
   import jt6295_pkg::*;
#(
   parameter int MW  = 32,
   parameter int MAW = ROM_AW - bsel_w(MW)
) (
   input  logic              rst,
   input  logic              clk,
   input  logic              inv,
   input  logic [ROM_AW-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              rom_ok,
   output logic [MAW-1:0]    mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [MW-1:0]     mem_data
);

   localparam int SW = bsel_w(MW);
`ifdef JT6295_ROM_PREFETCH_EN
   localparam int NE = 2;
`else
   localparam int NE = 1;
`endif

   logic [MAW-1:0]    cur_tag;
   logic [SW-1:0]     cur_sel;
   logic [NE-1:0]     hit;
   logic [NE-1:0]     wr;
   logic [7:0]        byte_q [NE];
   logic [7:0]        sel_byte;
   logic              any_hit;
   logic              fill;
   logic              discard;
   logic [1:0]        st;
   logic [ROM_AW-1:0] addr_l;
   logic              ok_r;

   assign cur_tag = rom_addr[ROM_AW-1:SW];
   assign cur_sel = rom_addr[SW-1:0];
   assign any_hit = |hit;

   // A word returning after an invalidate (or with one) must never land in a line.
   assign fill = mem_ack && (st != ST_IDLE) && !discard && !inv;

   for (genvar g = 0; g < NE; g++) begin : g_line
      jt6295_rom_line #(.MW(MW), .MAW(MAW), .SW(SW)) u_line (
         .rst     (rst),
         .clk     (clk),
         .clr     (inv),
         .wr      (wr[g]),
         .wr_tag  (mem_addr),
         .wr_data (mem_data),
         .rd_tag  (cur_tag),
         .rd_sel  (cur_sel),
         .hit     (hit[g]),
         .rd_byte (byte_q[g])
      );
   end

   always_comb begin
      sel_byte = byte_q[0];
      for (int i = 0; i < NE; i++) begin
         if (hit[i]) sel_byte = byte_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_l   <= '0;
         ok_r     <= 1'b0;
         rom_data <= 8'h00;
      end else begin
         addr_l <= rom_addr;
         ok_r   <= any_hit && !inv;
         if (any_hit) rom_data <= sel_byte;
      end
   end

   // ok_r belongs to addr_l; it must not leak onto a different address.
   assign rom_ok = ok_r && (rom_addr == addr_l);

`ifdef JT6295_ROM_PREFETCH_EN
   logic victim;
   logic last_hit;
   logic pf_pend;

   assign wr = fill ? (victim ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_hit <= 1'b0;
      end else if (any_hit) begin
         last_hit <= hit[1];
      end
   end
`else
   assign wr = fill;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= ST_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         discard  <= 1'b0;
`ifdef JT6295_ROM_PREFETCH_EN
         victim   <= 1'b0;
         pf_pend  <= 1'b0;
`endif
      end else begin
         case (st)
            ST_IDLE: begin
               if (!any_hit) begin
                  mem_addr <= cur_tag;
                  mem_req  <= 1'b1;
                  discard  <= 1'b0;
                  st       <= ST_WAIT;
`ifdef JT6295_ROM_PREFETCH_EN
                  victim   <= ~last_hit;
                  pf_pend  <= 1'b0;
               end else if (pf_pend && !inv) begin
                  // mem_addr still holds the word just filled; fetch its successor
                  mem_addr <= mem_addr + 1'b1;
                  mem_req  <= 1'b1;
                  discard  <= 1'b0;
                  victim   <= ~victim;
                  pf_pend  <= 1'b0;
                  st       <= ST_PREF;
               end else if (inv) begin
                  pf_pend  <= 1'b0;
`endif
               end
            end
            ST_WAIT, ST_PREF: begin
               if (inv) discard <= 1'b1;
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  st      <= ST_IDLE;
`ifdef JT6295_ROM_PREFETCH_EN
                  if (st == ST_WAIT && fill) pf_pend <= 1'b1;
`endif
               end
            end
            default: begin
               st      <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jt6295_rom_server.sv
// Directed bench for jt6295_rom_server (MW=32) with a latency-programmable memory responder.
module tb_jt6295_rom_server;

   logic        rst;
   logic        clk;
   logic        inv;
   logic [17:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ok;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_data;

   int asserts = 0;
   int fails   = 0;

   logic resp_en  = 1'b0;
   int   resp_lat = 3;
   int   resp_cnt = 0;

   jt6295_rom_server #(.MW(32), .MAW(16)) dut (
      .rst      (rst),
      .clk      (clk),
      .inv      (inv),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .mem_addr (mem_addr),
      .mem_req  (mem_req),
      .mem_ack  (mem_ack),
      .mem_data (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: byte k of word w = 0x11*(k+1) + w[7:0]
   function automatic logic [31:0] word(input logic [15:0] w);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(8'h11 * (k + 1)) + w[7:0];
      return r;
   endfunction

   // Responder: mem_ack is sampled on the resp_lat-th rising edge after mem_req rises
   always @(negedge clk) begin
      if (resp_en) begin
         if (mem_ack) begin
            mem_ack = 1'b0;
            resp_cnt = 0;
         end else if (mem_req) begin
            if (resp_cnt == resp_lat - 1) begin
               mem_ack  = 1'b1;
               mem_data = word(mem_addr);
               resp_cnt = 0;
            end else begin
               resp_cnt++;
            end
         end else begin
            resp_cnt = 0;
         end
      end else begin
         resp_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ok(input int limit, output int n);
      n = 0;
      while (rom_ok !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inv = 1'b0; rom_addr = 18'h00000; mem_ack = 1'b0; mem_data = 32'h0;
      tick(); tick();
      asserts++; if (rom_ok !== 1'b0) begin fails++; $display("FAIL reset_rom_ok: got %b want 0", rom_ok); end
      asserts++; if (rom_data !== 8'h00) begin fails++; $display("FAIL reset_rom_data: got %h want 00", rom_data); end
      asserts++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      asserts++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
   endtask

   task automatic test_first_fill();
      int n;
      resp_en = 1'b1; resp_lat = 3;
      rst = 1'b0;
      tick();
      asserts++; if (mem_req !== 1'b1) begin fails++; $display("FAIL fill_req: got %b want 1", mem_req); end
      asserts++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL fill_addr: got %h want 0000", mem_addr); end
      asserts++; if (rom_ok !== 1'b0) begin fails++; $display("FAIL fill_ok_early: got %b want 0", rom_ok); end
      wait_ok(20, n);
      asserts++; if (n !== 4) begin fails++; $display("FAIL fill_latency: got %0d edges want 4", n); end
      asserts++; if (rom_data !== 8'h11) begin fails++; $display("FAIL fill_data: got %h want 11", rom_data); end
   endtask

   task automatic test_sequential();
      logic [7:0] exp [3];
      exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44;
      for (int a = 1; a <= 3; a++) begin
         rom_addr = 18'(a);
         tick();
         asserts++; if (rom_ok !== 1'b1) begin fails++; $display("FAIL seq_ok[%0d]: got %b want 1", a, rom_ok); end
         asserts++; if (rom_data !== exp[a-1]) begin fails++; $display("FAIL seq_data[%0d]: got %h want %h", a, rom_data, exp[a-1]); end
         asserts++; if (mem_req !== 1'b0) begin fails++; $display("FAIL seq_req[%0d]: got %b want 0", a, mem_req); end
      end
   endtask

   task automatic test_change_during_wait();
      int n;
      rom_addr = 18'h00004;
      for (int c = 0; c < 3; c++) begin
         tick();
         asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin fails++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h want req=1 addr=0001", c, mem_req, mem_addr); end
         asserts++; if (rom_ok !== 1'b0) begin fails++; $display("FAIL wait_ok[%0d]: got %b want 0", c, rom_ok); end
      end
      rom_addr = 18'h00010;
      tick();
      asserts++; if (mem_req !== 1'b0 || rom_ok !== 1'b0) begin fails++; $display("FAIL wait_fill: got req=%b ok=%b want req=0 ok=0", mem_req, rom_ok); end
      tick();
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin fails++; $display("FAIL wait_second_req: got req=%b addr=%h want req=1 addr=0004", mem_req, mem_addr); end
      wait_ok(20, n);
      asserts++; if (n !== 4) begin fails++; $display("FAIL wait_second_latency: got %0d edges want 4", n); end
      asserts++; if (rom_data !== 8'h15) begin fails++; $display("FAIL wait_second_data: got %h want 15", rom_data); end
   endtask

   task automatic test_inv_with_ack();
      resp_en = 1'b0;
      rom_addr = 18'h00020;
      tick();
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0008) begin fails++; $display("FAIL inv_req: got req=%b addr=%h want req=1 addr=0008", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_data = word(16'h0008); inv = 1'b1;
      tick();
      mem_ack = 1'b0; inv = 1'b0;
      asserts++; if (mem_req !== 1'b0 || rom_ok !== 1'b0) begin fails++; $display("FAIL inv_drop: got req=%b ok=%b want req=0 ok=0", mem_req, rom_ok); end
      tick();
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0008 || rom_ok !== 1'b0) begin fails++; $display("FAIL inv_refetch: got req=%b addr=%h ok=%b want req=1 addr=0008 ok=0", mem_req, mem_addr, rom_ok); end
      mem_ack = 1'b1; mem_data = word(16'h0008);
      tick();
      mem_ack = 1'b0;
      tick();
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h19) begin fails++; $display("FAIL inv_refill: got ok=%b data=%h want ok=1 data=19", rom_ok, rom_data); end
   endtask

   task automatic test_reset_mid_fetch();
      int n;
      rom_addr = 18'h00040;
      tick();
      asserts++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
      #2 rst = 1'b1;
      #1;
      asserts++; if (mem_req !== 1'b0 || rom_ok !== 1'b0) begin fails++; $display("FAIL rstmid_async: got req=%b ok=%b want req=0 ok=0", mem_req, rom_ok); end
      tick();
      rst = 1'b0;
      mem_ack = 1'b1; mem_data = word(16'h0010);
      tick();
      mem_ack = 1'b0;
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || rom_ok !== 1'b0) begin fails++; $display("FAIL rstmid_miss: got req=%b addr=%h ok=%b want req=1 addr=0010 ok=0", mem_req, mem_addr, rom_ok); end
      tick();
      asserts++; if (mem_req !== 1'b1 || rom_ok !== 1'b0) begin fails++; $display("FAIL rstmid_stray: got req=%b ok=%b want req=1 ok=0", mem_req, rom_ok); end
      resp_en = 1'b1;
      wait_ok(20, n);
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h21) begin fails++; $display("FAIL rstmid_fill: got ok=%b data=%h want ok=1 data=21", rom_ok, rom_data); end
      resp_en = 1'b0;
      rom_addr = 18'h00041;
      mem_ack = 1'b1; mem_data = 32'h0;
      tick();
      mem_ack = 1'b0;
      tick();
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h32 || mem_req !== 1'b0) begin fails++; $display("FAIL idle_ack_ignored: got ok=%b data=%h req=%b want ok=1 data=32 req=0", rom_ok, rom_data, mem_req); end
   endtask

   task automatic test_top_word();
      int n;
      resp_en = 1'b1; resp_lat = 3;
      rom_addr = 18'h3FFFC;
      tick();
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin fails++; $display("FAIL top_req: got req=%b addr=%h want req=1 addr=ffff", mem_req, mem_addr); end
      wait_ok(20, n);
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h10) begin fails++; $display("FAIL top_data: got ok=%b data=%h want ok=1 data=10", rom_ok, rom_data); end
`ifdef JT6295_ROM_PREFETCH_EN
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin fails++; $display("FAIL pref_req: got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr); end
      n = 0;
      while (mem_req === 1'b1 && n < 20) begin tick(); n++; end
      asserts++; if (n >= 20) begin fails++; $display("FAIL pref_timeout: got req still 1 want 0"); end
      tick();
      rom_addr = 18'h00000;
      tick();
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h11 || mem_req !== 1'b0) begin fails++; $display("FAIL pref_hit: got ok=%b data=%h req=%b want ok=1 data=11 req=0", rom_ok, rom_data, mem_req); end
      rom_addr = 18'h3FFFF;
      tick();
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h43 || mem_req !== 1'b0) begin fails++; $display("FAIL pref_other: got ok=%b data=%h req=%b want ok=1 data=43 req=0", rom_ok, rom_data, mem_req); end
`else
      tick(); tick();
      asserts++; if (mem_req !== 1'b0) begin fails++; $display("FAIL no_prefetch: got req=%b want 0", mem_req); end
      rom_addr = 18'h00000;
      tick();
      asserts++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || rom_ok !== 1'b0) begin fails++; $display("FAIL wrap_miss: got req=%b addr=%h ok=%b want req=1 addr=0000 ok=0", mem_req, mem_addr, rom_ok); end
      wait_ok(20, n);
      asserts++; if (rom_ok !== 1'b1 || rom_data !== 8'h11) begin fails++; $display("FAIL wrap_fill: got ok=%b data=%h want ok=1 data=11", rom_ok, rom_data); end
`endif
      resp_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_fill();
      test_sequential();
      test_change_during_wait();
      test_inv_with_ack();
      test_reset_mid_fetch();
      test_top_word();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
